// File: rtl/sdram_write_buffer_pkg.sv
// rtl/sdram_write_buffer_pkg.sv - shared drain FSM encoding and entry layout constants
package sdram_write_buffer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_WRITE   = 4'b0010,
      ST_READ    = 4'b0100,
      ST_RELEASE = 4'b1000
   } drain_state_e;

   localparam logic [3:0] READ_MASK = 4'b1111;

   // Entry holds {address, data[31:0], nwr[3:0]}; the data + nwr part is fixed.
   localparam int ENTRY_PAYLOAD_W = 36;

   function automatic int entry_width(input int address_width);
      return address_width + ENTRY_PAYLOAD_W;
   endfunction

endpackage

// File: rtl/sdram_wbuf_fifo.sv
// rtl/sdram_wbuf_fifo.sv - posted-write FIFO storage with wrapping pointers and occupancy count
module sdram_wbuf_fifo #(
   parameter int WIDTH = 60,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = pop && !empty;
      // A full FIFO still accepts a push when the head leaves on the same edge.
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/sdram_write_buffer.sv
// rtl/sdram_write_buffer.sv - CPU-side posted-write buffer with drain FSM toward the SDRAM controller
module sdram_write_buffer
   import sdram_write_buffer_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 24,
   parameter int DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic [ADDRESS_WIDTH-1:0] cpu_address,
   input  logic [31:0]              cpu_data_in,
   output logic [31:0]              cpu_data_out,
   input  logic                     cpu_req,
   input  logic [3:0]               cpu_nwr,
   output logic                     cpu_ack,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [31:0]              mem_data_out,
   input  logic [31:0]              mem_data_in,
   output logic                     mem_req,
   output logic [3:0]               mem_nwr,
   input  logic                     mem_ack,
   output logic                     fifo_empty,
   output logic                     fifo_full
);

   localparam int ENTRY_W = entry_width(ADDRESS_WIDTH);

   drain_state_e             state_q, state_d;
   logic                     cpu_ack_q, cpu_ack_d;
   logic [31:0]              cpu_data_out_q, cpu_data_out_d;
   logic                     mem_req_q, mem_req_d;
   logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [31:0]              mem_data_out_q, mem_data_out_d;
   logic [3:0]               mem_nwr_q, mem_nwr_d;

   logic                     new_req, is_write, push, pop, read_pending, read_done;
   logic [ENTRY_W-1:0]       head;

   sdram_wbuf_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .nreset (nreset),
      .push   (push),
      .pop    (pop),
      .wdata  ({cpu_address, cpu_data_in, cpu_nwr}),
      .rdata  (head),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   always_comb begin
      new_req        = cpu_req && !cpu_ack_q;
      is_write       = (cpu_nwr != READ_MASK);
      pop            = (state_q == ST_WRITE) && mem_ack;
      push           = new_req && is_write && (!fifo_full || pop);
      read_pending   = new_req && !is_write;
      read_done      = 1'b0;
      state_d        = state_q;
      cpu_data_out_d = cpu_data_out_q;
      mem_req_d      = mem_req_q;
      mem_address_d  = mem_address_q;
      mem_data_out_d = mem_data_out_q;
      mem_nwr_d      = mem_nwr_q;
      case (state_q)
         ST_IDLE: begin
            // Posted writes drain before a waiting read so the read sees them.
            if (!fifo_empty) begin
               state_d        = ST_WRITE;
               mem_req_d      = 1'b1;
               mem_address_d  = head[ENTRY_W-1 -: ADDRESS_WIDTH];
               mem_data_out_d = head[35:4];
               mem_nwr_d      = head[3:0];
            end else if (read_pending) begin
               state_d       = ST_READ;
               mem_req_d     = 1'b1;
               mem_address_d = cpu_address;
               mem_nwr_d     = READ_MASK;
            end
         end
         ST_WRITE: begin
            if (mem_ack) begin
               state_d   = ST_RELEASE;
               mem_req_d = 1'b0;
            end
         end
         ST_READ: begin
            if (mem_ack) begin
               state_d        = ST_RELEASE;
               mem_req_d      = 1'b0;
               cpu_data_out_d = mem_data_in;
               read_done      = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!mem_ack) state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
      cpu_ack_d = cpu_ack_q ? cpu_req : (push || read_done);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q        <= ST_IDLE;
         cpu_ack_q      <= 1'b0;
         cpu_data_out_q <= '0;
         mem_req_q      <= 1'b0;
         mem_address_q  <= '0;
         mem_data_out_q <= '0;
         mem_nwr_q      <= READ_MASK;
      end else begin
         state_q        <= state_d;
         cpu_ack_q      <= cpu_ack_d;
         cpu_data_out_q <= cpu_data_out_d;
         mem_req_q      <= mem_req_d;
         mem_address_q  <= mem_address_d;
         mem_data_out_q <= mem_data_out_d;
         mem_nwr_q      <= mem_nwr_d;
      end
   end

   assign cpu_ack      = cpu_ack_q;
   assign cpu_data_out = cpu_data_out_q;
   assign mem_req      = mem_req_q;
   assign mem_address  = mem_address_q;
   assign mem_data_out = mem_data_out_q;
   assign mem_nwr      = mem_nwr_q;

endmodule

// File: tb/tb_sdram_write_buffer.sv
// tb/tb_sdram_write_buffer.sv - directed scoreboard bench for sdram_write_buffer
module tb_sdram_write_buffer;

   localparam int AW    = 24;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          nreset;
   logic [AW-1:0] cpu_address;
   logic [31:0]   cpu_data_in;
   logic [31:0]   cpu_data_out;
   logic          cpu_req;
   logic [3:0]    cpu_nwr;
   logic          cpu_ack;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_data_out;
   logic [31:0]   mem_data_in;
   logic          mem_req;
   logic [3:0]    mem_nwr;
   logic          mem_ack;
   logic          fifo_empty;
   logic          fifo_full;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [3:0]    nwr;
   } txn_t;

   txn_t        exp_q[$];
   logic [31:0] model_mem [int];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   sdram_write_buffer #(
      .ADDRESS_WIDTH (AW),
      .DEPTH         (DEPTH)
   ) dut (
      .clk          (clk),
      .nreset       (nreset),
      .cpu_address  (cpu_address),
      .cpu_data_in  (cpu_data_in),
      .cpu_data_out (cpu_data_out),
      .cpu_req      (cpu_req),
      .cpu_nwr      (cpu_nwr),
      .cpu_ack      (cpu_ack),
      .mem_address  (mem_address),
      .mem_data_out (mem_data_out),
      .mem_data_in  (mem_data_in),
      .mem_req      (mem_req),
      .mem_nwr      (mem_nwr),
      .mem_ack      (mem_ack),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] n, output int lat);
      txn_t t;
      t.addr = a; t.data = d; t.nwr = n;
      exp_q.push_back(t);
      cpu_address = a; cpu_data_in = d; cpu_nwr = n; cpu_req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!cpu_ack && lat < 50);
      check("write_ack_seen", 64'(cpu_ack), 64'd1);
      cpu_req = 1'b0;
      @(negedge clk);
      check("write_ack_clears", 64'(cpu_ack), 64'd0);
   endtask

   // Plays the SDRAM controller for one transaction and checks it against the scoreboard head.
   task automatic mem_serve();
      txn_t t;
      int   w = 0;
      while (!mem_req && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("mem_req_seen", 64'(mem_req), 64'd1);
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (!mem_req || exp_q.size() == 0) return;
      t = exp_q.pop_front();
      check("mem_address", 64'(mem_address), 64'(t.addr));
      check("mem_nwr", 64'(mem_nwr), 64'(t.nwr));
      if (t.nwr != 4'b1111) begin
         logic [31:0] cur;
         check("mem_data_out", 64'(mem_data_out), 64'(t.data));
         cur = model_mem.exists(int'(t.addr)) ? model_mem[int'(t.addr)] : 32'h0;
         for (int b = 0; b < 4; b++)
            if (!t.nwr[b]) cur[b*8 +: 8] = t.data[b*8 +: 8];
         model_mem[int'(t.addr)] = cur;
      end else begin
         mem_data_in = model_mem.exists(int'(t.addr)) ? model_mem[int'(t.addr)] : 32'h0;
      end
      @(negedge clk);
      check("mem_req_held", 64'(mem_req), 64'd1);
      check("mem_address_stable", 64'(mem_address), 64'(t.addr));
      mem_ack = 1'b1;
      @(negedge clk);
      check("mem_req_drop", 64'(mem_req), 64'd0);
      mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_read(input logic [AW-1:0] a, input int nserve, input logic [31:0] exp_data);
      txn_t t;
      t.addr = a; t.data = 32'h0; t.nwr = 4'b1111;
      exp_q.push_back(t);
      cpu_address = a; cpu_nwr = 4'b1111; cpu_req = 1'b1;
      repeat (nserve) mem_serve();
      check("read_ack", 64'(cpu_ack), 64'd1);
      check("read_data", 64'(cpu_data_out), 64'(exp_data));
      cpu_req = 1'b0;
      @(negedge clk);
      check("read_ack_clears", 64'(cpu_ack), 64'd0);
      check("read_data_holds", 64'(cpu_data_out), 64'(exp_data));
   endtask

   initial begin
      int  lat;
      bit  stray;
      nreset = 1'b0; cpu_req = 1'b0; cpu_nwr = 4'b1111; cpu_address = '0;
      cpu_data_in = '0; mem_ack = 1'b0; mem_data_in = '0;
      repeat (3) @(negedge clk);
      check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_nwr", 64'(mem_nwr), 64'hF);
      check("rst_cpu_data_out", 64'(cpu_data_out), 64'd0);
      check("rst_fifo_empty", 64'(fifo_empty), 64'd1);
      check("rst_fifo_full", 64'(fifo_full), 64'd0);
      nreset = 1'b1;
      @(negedge clk);

      // Single full-word write
      cpu_write(24'h000010, 32'hDEADBEEF, 4'b0000, lat);
      check("write_latency", 64'(lat), 64'd1);
      check("pending_not_empty", 64'(fifo_empty), 64'd0);
      mem_serve();
      check("drained_empty", 64'(fifo_empty), 64'd1);

      // Five writes with the controller stalled
      for (int i = 0; i < 4; i++)
         cpu_write(24'h000100 + AW'(i), 32'hC0DE0000 + 32'(i), 4'b0000, lat);
      check("four_full", 64'(fifo_full), 64'd1);
      check("head_requested", 64'(mem_req), 64'd1);
      begin
         txn_t t;
         t.addr = 24'h000104; t.data = 32'hC0DE0004; t.nwr = 4'b0000;
         exp_q.push_back(t);
      end
      cpu_address = 24'h000104; cpu_data_in = 32'hC0DE0004; cpu_nwr = 4'b0000; cpu_req = 1'b1;
      repeat (5) @(negedge clk);
      check("fifth_held", 64'(cpu_ack), 64'd0);
      mem_serve();
      check("fifth_acked", 64'(cpu_ack), 64'd1);
      check("full_after_swap", 64'(fifo_full), 64'd1);
      cpu_req = 1'b0;
      @(negedge clk);
      repeat (4) mem_serve();
      check("wrap_drained_empty", 64'(fifo_empty), 64'd1);
      check("wrap_drained_not_full", 64'(fifo_full), 64'd0);

      // Read-after-write ordering, then a byte-masked write
      cpu_write(24'h000020, 32'h12345678, 4'b0000, lat);
      cpu_read(24'h000020, 2, 32'h12345678);
      cpu_write(24'h000030, 32'hAABBCCDD, 4'b1100, lat);
      cpu_read(24'h000030, 2, 32'h0000CCDD);

      // Reset while draining three entries
      for (int i = 0; i < 3; i++)
         cpu_write(24'h000200 + AW'(i), 32'h5A5A0000 + 32'(i), 4'b0000, lat);
      check("drain_active", 64'(mem_req), 64'd1);
      nreset = 1'b0;
      #1;
      check("async_rst_mem_req", 64'(mem_req), 64'd0);
      check("async_rst_fifo_empty", 64'(fifo_empty), 64'd1);
      check("async_rst_mem_nwr", 64'(mem_nwr), 64'hF);
      check("async_rst_cpu_data_out", 64'(cpu_data_out), 64'd0);
      exp_q.delete();
      @(negedge clk);
      nreset = 1'b1;
      stray = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (mem_req) stray = 1'b1;
      end
      check("no_req_after_reset", 64'(stray), 64'd0);
      check("empty_after_reset", 64'(fifo_empty), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_write_buffer.md
SDRAM_WRITE_BUFFER -- requirements
Module: sdram_write_buffer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 24, word address width (bank + row + column + chip select bit).
REQ-002 Parameter DEPTH, default 4, posted-write FIFO entries; power of two, min 2.
REQ-003 Port clk  input  1  single clock; all logic on posedge.
REQ-004 Port nreset  input  1  reset, asynchronous, active-low.
REQ-005 Port cpu_address  input  ADDRESS_WIDTH  CPU word address.
REQ-006 Port cpu_data_in  input  32  CPU write data.
REQ-007 Port cpu_data_out  output  32  read data to CPU.
REQ-008 Port cpu_req  input  1  CPU request; held high until cpu_ack seen.
REQ-009 Port cpu_nwr  input  4  active-low byte write enables; 4'b1111 = read.
REQ-010 Port cpu_ack  output  1  CPU acknowledge.
REQ-011 Port mem_address  output  ADDRESS_WIDTH  address to SDRAM controller.
REQ-012 Port mem_data_out  output  32  write data to SDRAM controller.
REQ-013 Port mem_data_in  input  32  read data from SDRAM controller.
REQ-014 Port mem_req  output  1  request to SDRAM controller.
REQ-015 Port mem_nwr  output  4  byte write enables to SDRAM controller.
REQ-016 Port mem_ack  input  1  SDRAM controller acknowledge; stays high until mem_req low.
REQ-017 Port fifo_empty  output  1  no posted writes pending.
REQ-018 Port fifo_full  output  1  DEPTH writes pending.

Function
REQ-019 New CPU request SHALL be recognised only when cpu_req=1 and cpu_ack=0.
REQ-020 cpu_ack, once high, SHALL stay high until cpu_req=0, then clear on the next edge.
REQ-021 CPU write (cpu_nwr != 4'b1111) with FIFO not full: push {address, data, nwr}, cpu_ack=1 next edge (1-cycle latency).
REQ-022 CPU write with FIFO full: no push, no ack until an entry pops; then push and ack as REQ-021.
REQ-023 CPU read: SHALL wait until FIFO empty and drain FSM in IDLE, then issue downstream read with mem_nwr=4'b1111.
REQ-024 Read data: cpu_data_out SHALL latch mem_data_in on the edge mem_ack is first seen high; cpu_ack=1 same edge; cpu_data_out holds until next read completes.
REQ-025 Drain FSM states: IDLE, WRITE, READ, RELEASE.
REQ-026 IDLE->WRITE when FIFO non-empty (writes take priority over pending read); drives head entry, mem_req=1.
REQ-027 IDLE->READ when FIFO empty and recognised read pending; mem_req=1.
REQ-028 WRITE/READ->RELEASE on mem_ack=1: mem_req=0; WRITE pops head same edge.
REQ-029 RELEASE->IDLE when mem_ack=0; no new mem_req issued before that.
REQ-030 mem_address/mem_data_out/mem_nwr SHALL be stable while mem_req=1.
REQ-031 Simultaneous push and pop SHALL leave count unchanged; push while full and popping SHALL be accepted.
REQ-032 Read/write pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-033 fifo_empty/fifo_full SHALL be registered-state decodes valid every cycle.

Reset
REQ-034 nreset low SHALL asynchronously force: cpu_ack=0, mem_req=0, mem_nwr=4'b1111, cpu_data_out=0, pointers/count=0, FSM=IDLE, fifo_empty=1, fifo_full=0.
REQ-035 Reset mid-transfer SHALL discard pending writes and any pending read; no recovery.

Structure
REQ-036 Shared package SHALL hold drain FSM state encoding (one-hot), READ_MASK=4'b1111, entry width constant ADDRESS_WIDTH+36.
REQ-037 FIFO storage/pointers SHALL be one sub-module sdram_wbuf_fifo; handshake and drain FSM in top.

Verification
REQ-038 Single write addr 0x000010 data 0xDEADBEEF nwr 4'b0000 -> cpu_ack 1 cycle later; mem request with same values; fifo_empty returns 1 after mem_ack.
REQ-039 Five back-to-back writes, mem_ack held off -> four acked, fifo_full=1, fifth acked only after first pop.
REQ-040 Write 0x000020=0x12345678 then read 0x000020 -> read mem_req only after write popped; cpu_data_out=model value 0x12345678.
REQ-041 Byte write nwr 4'b1100 data 0xAABBCCDD -> mem_nwr=4'b1100 passed unchanged.
REQ-042 Push on same edge as pop with count=DEPTH -> count stays DEPTH, order preserved across pointer wrap.
REQ-043 nreset low during WRITE with 3 entries -> mem_req=0, fifo_empty=1 immediately, no further downstream requests.
